// File: rtl/sramlike_mem_slave_if.sv
// sramlike_mem_slave_if: sram_like data bus between a CPU-side initiator and a memory responder
// Ports (master drives / slave drives):
//   data_req, data_wr, data_size[1:0], data_addr[31:0], data_wdata[31:0], busy  : initiator -> responder
//   data_addr_ok, data_data_ok, data_rdata[31:0], misalign_err                  : responder -> initiator
interface sramlike_mem_slave_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        busy;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        misalign_err;
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, busy,
    input  data_addr_ok, data_data_ok, data_rdata, misalign_err
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, busy,
    output data_addr_ok, data_data_ok, data_rdata, misalign_err
  );
endinterface

// File: rtl/sramlike_mem_slave.sv
// sramlike_mem_slave: sram_like responder backed by a word array with fixed-latency in-order responses
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : sram_like slave modport (request in, addr_ok/data_ok/rdata/misalign_err out, busy back-pressure in)
module sramlike_mem_slave #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sramlike_mem_slave_if.slave  bus
);
  logic [31:0]        mem_q [2**ADDR_W];
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] mis_q;
  logic [31:0]        rd_q [LATENCY];
  logic [3:0]         inflight_q;
  logic [3:0]         inflight_d;
  logic [ADDR_W-1:0]  idx;
  logic [3:0]         strb;
  logic               mis;
  logic               acc;
  logic               rsp;
  assign idx = bus.data_addr[ADDR_W+1:2];
  assign rsp = vld_q[LATENCY-1];
  assign strb = bus.data_size == 2'd0 ? 4'b0001 << bus.data_addr[1:0] :
                bus.data_size == 2'd1 ? (bus.data_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign mis = (bus.data_size == 2'd1 & bus.data_addr[0]) | (bus.data_size[1] & bus.data_addr[1:0] != 2'd0);
  // the head response leaving this cycle frees its slot for a same-cycle accept
  assign bus.data_addr_ok = bus.data_req & ~bus.busy & ~rst & (inflight_q - {3'b0, rsp} < 4'(MAX_OUT));
  assign acc = bus.data_req & bus.data_addr_ok;
  assign inflight_d = inflight_q + {3'b0, acc} - {3'b0, rsp};
  assign bus.data_data_ok = rsp;
  assign bus.data_rdata = rd_q[LATENCY-1];
  assign bus.misalign_err = mis_q[LATENCY-1];
  // idle stages carry zero data so rdata is zero whenever data_ok is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      mis_q <= '0;
      inflight_q <= '0;
      for (int k = 0; k < LATENCY; k++) rd_q[k] <= '0;
    end else begin
      vld_q[0] <= acc;
      mis_q[0] <= acc & mis;
      rd_q[0] <= acc & ~bus.data_wr ? mem_q[idx] : 32'h0;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        mis_q[k] <= mis_q[k-1];
        rd_q[k] <= rd_q[k-1];
      end
      inflight_q <= inflight_d;
    end
  end
  // array is not reset; misaligned writes are answered but leave memory untouched
  always_ff @(posedge clk) begin
    if (acc & bus.data_wr & ~mis)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem_q[idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_sramlike_mem_slave.sv
// tb_sramlike_mem_slave: scoreboard bench for two sramlike_mem_slave configurations
module tb_sramlike_mem_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int nb = 0;
  logic [31:0] last_a = 32'h0;
  logic last_m = 1'b0;
  logic [31:0] mdl [1024];
  typedef struct {logic [31:0] d; logic m; int c;} exp_t;
  exp_t qa[$];
  exp_t qb[$];

  sramlike_mem_slave_if a_if();
  sramlike_mem_slave_if b_if();

  sramlike_mem_slave #(.ADDR_W(10), .LATENCY(2), .MAX_OUT(2)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  sramlike_mem_slave #(.ADDR_W(10), .LATENCY(3), .MAX_OUT(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] strb_f(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0: return 4'b0001 << a;
      2'd1: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic mis_f(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'd1 && a[0]) || (sz[1] && a != 2'd0);
  endfunction

  always @(negedge clk) begin : mon_a
    exp_t e;
    logic [3:0] s;
    checks++;
    if (a_if.data_data_ok) begin
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_resp unexpected data_ok at cycle %0d", cyc);
      end else begin
        e = qa.pop_front();
        last_a = a_if.data_rdata;
        last_m = a_if.misalign_err;
        if (a_if.data_rdata !== e.d || a_if.misalign_err !== e.m || cyc != e.c) begin
          errors++;
          $display("FAIL a_resp got rdata=%h mis=%b cycle=%0d want rdata=%h mis=%b cycle=%0d",
                   a_if.data_rdata, a_if.misalign_err, cyc, e.d, e.m, e.c);
        end
      end
    end else if (a_if.data_rdata !== 32'h0 || a_if.misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL a_idle got rdata=%h mis=%b want 00000000 0", a_if.data_rdata, a_if.misalign_err);
    end
    if (a_if.data_req && a_if.data_addr_ok) begin
      e.d = a_if.data_wr ? 32'h0 : mdl[a_if.data_addr[11:2]];
      e.m = mis_f(a_if.data_size, a_if.data_addr[1:0]);
      e.c = cyc + 2;
      qa.push_back(e);
      s = strb_f(a_if.data_size, a_if.data_addr[1:0]);
      if (a_if.data_wr && !e.m)
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl[a_if.data_addr[11:2]][8*b +: 8] = a_if.data_wdata[8*b +: 8];
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    checks++;
    if (b_if.data_data_ok) begin
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_resp unexpected data_ok at cycle %0d", cyc);
      end else begin
        e = qb.pop_front();
        if (b_if.data_rdata !== e.d || b_if.misalign_err !== e.m || cyc != e.c) begin
          errors++;
          $display("FAIL b_resp got rdata=%h mis=%b cycle=%0d want rdata=%h mis=%b cycle=%0d",
                   b_if.data_rdata, b_if.misalign_err, cyc, e.d, e.m, e.c);
        end
      end
    end
    if (b_if.data_req && b_if.data_addr_ok) begin
      checks++;
      if (nb > 0 && !b_if.data_data_ok) begin
        errors++;
        $display("FAIL b_slot accept #%0d got data_ok=%b want 1", nb, b_if.data_data_ok);
      end
      nb++;
      e.d = 32'h0;
      e.m = mis_f(b_if.data_size, b_if.data_addr[1:0]);
      e.c = cyc + 3;
      qb.push_back(e);
    end
    checks++;
    if (qb.size() > 1) begin
      errors++;
      $display("FAIL b_inflight got %0d want <=1", qb.size());
    end
  end

  task automatic xfer(input bit sel, input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                      input logic [31:0] wd, output int w);
    if (sel) begin
      b_if.data_req = 1; b_if.data_wr = wr; b_if.data_size = sz; b_if.data_addr = ad; b_if.data_wdata = wd;
    end else begin
      a_if.data_req = 1; a_if.data_wr = wr; a_if.data_size = sz; a_if.data_addr = ad; a_if.data_wdata = wd;
    end
    w = 0;
    @(negedge clk);
    while (!(sel ? b_if.data_addr_ok : a_if.data_addr_ok) && w < 50) begin
      w++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if (sel) b_if.data_req = 0;
    else a_if.data_req = 0;
  endtask

  task automatic drain;
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain pending a=%0d b=%0d want 0 0", qa.size(), qb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_if.data_req = 1; a_if.data_wr = 0; a_if.data_size = 2; a_if.data_addr = 32'h10;
    repeat (2) @(negedge clk);
    checks++;
    if (a_if.data_addr_ok !== 1'b0 || a_if.data_data_ok !== 1'b0 || a_if.data_rdata !== 32'h0 || a_if.misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got addr_ok=%b data_ok=%b rdata=%h mis=%b want 0 0 00000000 0",
               a_if.data_addr_ok, a_if.data_data_ok, a_if.data_rdata, a_if.misalign_err);
    end
    a_if.data_req = 0;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if (a_if.data_data_ok !== 1'b0 || b_if.data_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got data_ok a=%b b=%b want 0 0", a_if.data_data_ok, b_if.data_data_ok);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int w;
    xfer(0, 1, 2, 32'h10, 32'hDEADBEEF, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL basic_wr_wait got %0d want 0", w); end
    xfer(0, 0, 2, 32'h10, 32'h0, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL basic_rd_wait got %0d want 0", w); end
    repeat (2) @(negedge clk);
    checks++;
    if (a_if.data_data_ok !== 1'b1 || a_if.data_rdata !== 32'hDEADBEEF || a_if.misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_rd got data_ok=%b rdata=%h mis=%b want 1 deadbeef 0",
               a_if.data_data_ok, a_if.data_rdata, a_if.misalign_err);
    end
    drain();
  endtask

  task automatic test_subword;
    int w;
    xfer(0, 1, 2, 32'h20, 32'h0, w);
    xfer(0, 1, 0, 32'h21, 32'h0000AA00, w);
    xfer(0, 1, 1, 32'h22, 32'h12340000, w);
    xfer(0, 0, 2, 32'h20, 32'h0, w);
    drain();
    checks++;
    if (last_a !== 32'h1234AA00 || last_m !== 1'b0) begin
      errors++;
      $display("FAIL subword got rdata=%h mis=%b want 1234aa00 0", last_a, last_m);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    for (int i = 0; i < 4; i++) xfer(0, 1, 2, 32'h40 + 4 * i, 32'hA0000000 + i, w);
    drain();
    for (int i = 0; i < 4; i++) begin
      xfer(0, 0, 2, 32'h40 + 4 * i, 32'h0, w);
      checks++;
      if (w != 0) begin errors++; $display("FAIL b2b_wait[%0d] got %0d want 0", i, w); end
    end
    drain();
    checks++;
    if (last_a !== 32'hA0000003) begin
      errors++;
      $display("FAIL b2b_last got %h want a0000003", last_a);
    end
  endtask

  task automatic test_max_out1;
    int w;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1, 2, 32'h4 * i, i, w);
      checks++;
      if (w != (i == 0 ? 0 : 2)) begin
        errors++;
        $display("FAIL mo1_wait[%0d] got %0d want %0d", i, w, i == 0 ? 0 : 2);
      end
    end
    drain();
  endtask

  task automatic test_misalign;
    int w;
    xfer(0, 1, 2, 32'h30, 32'h11223344, w);
    xfer(0, 1, 2, 32'h31, 32'hFFFFFFFF, w);
    drain();
    checks++;
    if (last_m !== 1'b1 || last_a !== 32'h0) begin
      errors++;
      $display("FAIL mis_wr got mis=%b rdata=%h want 1 00000000", last_m, last_a);
    end
    xfer(0, 0, 2, 32'h1030, 32'h0, w);
    drain();
    checks++;
    if (last_a !== 32'h11223344 || last_m !== 1'b0) begin
      errors++;
      $display("FAIL mis_alias_rd got rdata=%h mis=%b want 11223344 0", last_a, last_m);
    end
    xfer(0, 0, 1, 32'h33, 32'h0, w);
    drain();
    checks++;
    if (last_a !== 32'h11223344 || last_m !== 1'b1) begin
      errors++;
      $display("FAIL mis_rd got rdata=%h mis=%b want 11223344 1", last_a, last_m);
    end
    xfer(0, 1, 3, 32'h34, 32'hCAFEF00D, w);
    xfer(0, 0, 3, 32'h34, 32'h0, w);
    drain();
    checks++;
    if (last_a !== 32'hCAFEF00D || last_m !== 1'b0) begin
      errors++;
      $display("FAIL size3 got rdata=%h mis=%b want cafef00d 0", last_a, last_m);
    end
  endtask

  task automatic test_busy_reset;
    int w;
    bit seen = 0;
    xfer(0, 0, 2, 32'h10, 32'h0, w);
    a_if.busy = 1; a_if.data_req = 1; a_if.data_wr = 0; a_if.data_size = 2; a_if.data_addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_if.data_data_ok) seen = 1;
      checks++;
      if (a_if.data_addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL busy_block[%0d] got addr_ok=%b want 0", i, a_if.data_addr_ok);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL busy_inflight got no data_ok want 1"); end
    a_if.busy = 0;
    xfer(0, 0, 2, 32'h40, 32'h0, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL busy_release_wait got %0d want 0", w); end
    xfer(0, 0, 2, 32'h44, 32'h0, w);
    rst = 1;
    qa.delete();
    qb.delete();
    #1;
    checks++;
    if (a_if.data_data_ok !== 1'b0 || a_if.data_rdata !== 32'h0 || a_if.misalign_err !== 1'b0 || a_if.data_addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got data_ok=%b rdata=%h mis=%b addr_ok=%b want 0 00000000 0 0",
               a_if.data_data_ok, a_if.data_rdata, a_if.misalign_err, a_if.data_addr_ok);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    xfer(0, 0, 2, 32'h10, 32'h0, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL post_reset_wait got %0d want 0", w); end
    drain();
    checks++;
    if (last_a !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL post_reset_rd got %h want deadbeef", last_a);
    end
  endtask

  initial begin
    a_if.data_req = 0; a_if.data_wr = 0; a_if.data_size = 0; a_if.data_addr = 0; a_if.data_wdata = 0; a_if.busy = 0;
    b_if.data_req = 0; b_if.data_wr = 0; b_if.data_size = 0; b_if.data_addr = 0; b_if.data_wdata = 0; b_if.busy = 0;
    test_reset();
    test_basic();
    test_subword();
    test_back_to_back();
    test_max_out1();
    test_misalign();
    test_busy_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
